// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch stage sitting directly behind the PC register. It keeps
//   at most one request outstanding to instruction memory, buffers returned
//   words with their PCs in a DEPTH-entry FIFO, and presents one instruction
//   per cycle to decode, under stall[1].
//
//   Ports
//     clk, reset     clock, synchronous active-high reset
//     pc, ce         fetch address and enable from the PC register
//     stall[5:0]     shared stall vector; only bit1 (IF/decode) is acted on here
//     flush          branch taken in decode: squash buffered and in-flight work
//     imem_req/addr  request to instruction memory, held until imem_ack
//     imem_ack/rdata memory response
//     stallreq_if    hold-PC request to the stall controller
//     id_pc/inst     instruction handed to decode
//     id_valid       1 = real instruction, 0 = bubble
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        ce,
  input  logic [5:0]  stall,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        stallreq_if,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid
);

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  state_t          state, state_nxt;
  logic [31:0]     req_pc;
  logic            discard;   // in-flight fetch was flushed; drop its data
  logic            issue, ack_done, push, pop;
  logic            full, empty;

  entry_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]  count;

  // stall[0] belongs to the PC register; upper bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    ack_done  = 1'b0;
    case (state)
      IDLE: begin
        if (ce && !full && !flush) begin
          issue     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          ack_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A flush in the same cycle as the ack also suppresses the push.
  assign push = ack_done & ~discard & ~flush;
  assign pop  = ~flush & ~stall[1] & ~empty;

  // Request registers. Address and PC stay stable for the whole WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      req_pc    <= '0;
      discard   <= 1'b0;
    end else if (issue) begin
      imem_req  <= 1'b1;
      imem_addr <= pc;
      req_pc    <= pc;
      discard   <= 1'b0;
    end else if (ack_done) begin
      imem_req  <= 1'b0;
    end else if (state == WAIT && flush) begin
      discard   <= 1'b1;
    end
  end

  // Registered state only: no combinational path from the stall controller.
  assign stallreq_if = ce & ((state == WAIT) | full);

  // ---------------------------------------------------------------------------
  // FIFO (pointers wrap naturally since DEPTH is a power of two)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: req_pc, inst: imem_rdata};
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      id_pc    <= '0;
      id_inst  <= '0;
      id_valid <= 1'b0;
    end else if (!stall[1]) begin
      if (!empty) begin
        id_pc    <= mem[rd_ptr].pc;
        id_inst  <= mem[rd_ptr].inst;
        id_valid <= 1'b1;
      end else begin
        id_pc    <= '0;
        id_inst  <= '0;
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        ce;
  logic [5:0]  stall;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stallreq_if;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;

  int total = 0;
  int bad   = 0;

  if_fetch_queue #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .pc(pc), .ce(ce), .stall(stall), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stallreq_if(stallreq_if),
    .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one fetch at addr, ack lat cycles after the issuing edge with data.
  // Returns just after the ack edge with ce=0.
  task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int lat);
    pc = addr;
    ce = 1'b1;
    tick();
    chk("fetch_req", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", imem_addr, addr);
    chk("fetch_stallreq", {31'd0, stallreq_if}, 32'd1);
    for (int k = 1; k < lat; k++) begin
      tick();
      chk("fetch_hold_addr", imem_addr, addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    ce         = 1'b0;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
  endtask

  initial begin
    reset = 1'b1; pc = '0; ce = 1'b0; stall = '0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;

    // Reset release and first fetch
    tick(); tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_count", {29'd0, dut.count}, 32'd0);
    reset = 1'b0; ce = 1'b1; pc = 32'h0;
    #1;
    chk("idle_stallreq", {31'd0, stallreq_if}, 32'd0);
    tick();
    chk("t1_req", {31'd0, imem_req}, 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    chk("t1_stallreq", {31'd0, stallreq_if}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h11111111; ce = 1'b0;
    tick();
    imem_ack = 1'b0;
    chk("t1_req_drop", {31'd0, imem_req}, 32'd0);
    chk("t1_no_bypass", {31'd0, id_valid}, 32'd0);
    tick();
    chk("t1_id_pc", id_pc, 32'h0);
    chk("t1_id_inst", id_inst, 32'h11111111);
    chk("t1_id_valid", {31'd0, id_valid}, 32'd1);
    tick();
    chk("t1_bubble", {31'd0, id_valid}, 32'd0);

    // Streaming with 3-cycle memory latency
    for (int i = 0; i < 4; i++) begin
      fetch(32'(i * 4), 32'hA0000000 + 32'(i), 3);
      tick();
      chk("st_valid", {31'd0, id_valid}, 32'd1);
      chk("st_pc", id_pc, 32'(i * 4));
      chk("st_inst", id_inst, 32'hA0000000 + 32'(i));
      tick();
      chk("st_bubble_v", {31'd0, id_valid}, 32'd0);
      chk("st_bubble_i", id_inst, 32'd0);
    end

    // Fill the FIFO under decode stall
    stall = 6'b000010;
    for (int i = 0; i < 4; i++) fetch(32'h40 + 32'(i * 4), 32'hB0 + 32'(i), 1);
    chk("full_count", {29'd0, dut.count}, 32'd4);
    pc = 32'h50; ce = 1'b1;
    #1;
    chk("full_stallreq", {31'd0, stallreq_if}, 32'd1);
    tick();
    chk("full_no_req0", {31'd0, imem_req}, 32'd0);
    tick();
    chk("full_no_req1", {31'd0, imem_req}, 32'd0);
    stall = '0;
    tick();
    chk("drain0_pc", id_pc, 32'h40);
    chk("drain0_v", {31'd0, id_valid}, 32'd1);
    tick();
    chk("drain1_pc", id_pc, 32'h44);
    chk("resume_req", {31'd0, imem_req}, 32'd1);
    chk("resume_addr", imem_addr, 32'h50);
    ce = 1'b0;
    tick();
    chk("drain2_pc", id_pc, 32'h48);
    tick();
    chk("drain3_pc", id_pc, 32'h4C);
    chk("drain3_inst", id_inst, 32'hB3);
    tick();
    chk("drain_bubble", {31'd0, id_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hC0;
    tick();
    imem_ack = 1'b0;
    tick();
    chk("resume_id_pc", id_pc, 32'h50);
    chk("resume_id_v", {31'd0, id_valid}, 32'd1);

    // Flush with a fetch in flight and one buffered entry
    stall = 6'b000010;
    fetch(32'h10, 32'h10101010, 1);
    chk("fl_held_v", {31'd0, id_valid}, 32'd1);
    pc = 32'h20; ce = 1'b1;
    tick();
    chk("fl_req_addr", imem_addr, 32'h20);
    ce = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", {31'd0, id_valid}, 32'd0);
    chk("fl_count", {29'd0, dut.count}, 32'd0);
    chk("fl_req_held", {31'd0, imem_req}, 32'd1);
    stall = '0;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_ack = 1'b0; imem_rdata = '0;
    chk("fl_ack_req", {31'd0, imem_req}, 32'd0);
    chk("fl_ack_count", {29'd0, dut.count}, 32'd0);
    tick();
    chk("fl_no_dead_v", {31'd0, id_valid}, 32'd0);
    chk("fl_no_dead_i", id_inst, 32'd0);
    fetch(32'h100, 32'h0A0A0A0A, 1);
    chk("fl_after_inst", id_inst, 32'd0);
    tick();
    chk("fl_new_pc", id_pc, 32'h100);
    chk("fl_new_inst", id_inst, 32'h0A0A0A0A);

    // Flush coinciding with an ack while two entries are buffered
    stall = 6'b000010;
    fetch(32'h200, 32'h21, 1);
    fetch(32'h204, 32'h22, 1);
    chk("fa_count2", {29'd0, dut.count}, 32'd2);
    pc = 32'h208; ce = 1'b1;
    tick();
    ce = 1'b0;
    chk("fa_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b1; imem_rdata = 32'h33; flush = 1'b1;
    tick();
    imem_ack = 1'b0; flush = 1'b0;
    chk("fa_count0", {29'd0, dut.count}, 32'd0);
    chk("fa_valid", {31'd0, id_valid}, 32'd0);
    chk("fa_req_drop", {31'd0, imem_req}, 32'd0);
    stall = '0;
    tick();
    chk("fa_no_out", {31'd0, id_valid}, 32'd0);

    // Reset in the middle of a request
    fetch(32'h3F0, 32'h44, 1);
    pc = 32'h400; ce = 1'b1;
    tick();
    chk("mr_valid_pre", {31'd0, id_valid}, 32'd1);
    chk("mr_pc_pre", id_pc, 32'h3F0);
    chk("mr_req_pre", {31'd0, imem_req}, 32'd1);
    chk("mr_addr_pre", imem_addr, 32'h400);
    ce = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_valid", {31'd0, id_valid}, 32'd0);
    chk("mr_addr", imem_addr, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'h55;
    tick();
    imem_ack = 1'b0;
    chk("mr_stray_count", {29'd0, dut.count}, 32'd0);
    chk("mr_stray_req", {31'd0, imem_req}, 32'd0);
    tick();
    chk("mr_stray_out", {31'd0, id_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
